pipelined_float_to_integer_converter: RTL and testbench

//  Converts an IEEE-754 binary float to a signed or unsigned integer of width INTEGER_WIDTH.

---
 rtl/pipelined_float_to_integer_converter.sv | 217 +++++++++++++++++++++
 tb/tb_pipelined_float_to_integer_converter.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_float_to_integer_converter.sv
// Two-stage IEEE-754 float to signed/unsigned integer converter (FCVT.W[U]/L[U] semantics).
// Stage 1 decodes and aligns the operand; stage 2 rounds, saturates and raises NV/NX.
module pipelined_float_to_integer_converter #(
    parameter int unsigned INTEGER_WIDTH  = 32,
    parameter int unsigned EXPONENT_WIDTH = 8,
    parameter int unsigned MANTISSA_WIDTH = 23
) (
    input  logic                                    clock,
    input  logic                                    reset,
    input  logic                                    input_valid,
    output logic                                    input_ready,
    input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0]  input_float,
    input  logic                                    sign_mode,
    input  logic [2:0]                              rounding_mode,
    output logic                                    output_valid,
    input  logic                                    output_ready,
    output logic [INTEGER_WIDTH-1:0]                converted_integer,
    output logic                                    flag_invalid,
    output logic                                    flag_inexact
);

    localparam int unsigned W    = INTEGER_WIDTH;
    localparam int unsigned E    = EXPONENT_WIDTH;
    localparam int unsigned M    = MANTISSA_WIDTH;
    localparam int unsigned FW   = 1 + E + M;
    localparam int          BIAS = 2 ** (E - 1) - 1;
    // Aligned value: W+1 integer bits, one guard bit, M+1 bits feeding sticky.
    localparam int unsigned VW   = W + M + 3;
    localparam int unsigned SW   = $clog2(W + 3);

    localparam logic [W+1:0] SMAX_MAG = {3'b000, {(W - 1){1'b1}}};
    localparam logic [W+1:0] SMIN_MAG = {2'b00, 1'b1, {(W - 1){1'b0}}};
    localparam logic [W+1:0] UMAX_MAG = {2'b00, {W{1'b1}}};
    localparam logic [W-1:0] SMAX     = {1'b0, {(W - 1){1'b1}}};
    localparam logic [W-1:0] SMIN     = {1'b1, {(W - 1){1'b0}}};
    localparam logic [W-1:0] UMAX     = '1;

    typedef enum logic [2:0] {
        ClsZero,
        ClsSubnormal,
        ClsNormal,
        ClsInf,
        ClsNan
    } float_class_e;

    logic advance;

    assign advance     = !output_valid || output_ready;
    assign input_ready = advance;

    // ------------------------------------------------------------------
    // Stage 1: decode and align
    // ------------------------------------------------------------------
    logic                 in_sign;
    logic [E-1:0]         exp_field;
    logic [M-1:0]         man_field;
    float_class_e         in_cls;
    int                   e_unb;
    logic [M:0]           significand;
    logic [VW-1:0]        aligned;
    logic [W:0]           d1_int;
    logic                 d1_guard;
    logic                 d1_sticky;
    logic                 d1_huge;

    assign in_sign   = input_float[FW-1];
    assign exp_field = input_float[FW-2:M];
    assign man_field = input_float[M-1:0];

    always_comb begin
        in_cls = ClsNormal;
        if (exp_field == '1) begin
            in_cls = (man_field == '0) ? ClsInf : ClsNan;
        end else if (exp_field == '0) begin
            in_cls = (man_field == '0) ? ClsZero : ClsSubnormal;
        end
    end

    always_comb begin
        significand = {(exp_field != '0), man_field};
        // Subnormals share the minimum normal exponent.
        e_unb       = (exp_field == '0) ? (1 - BIAS) : (int'(exp_field) - BIAS);
        aligned     = '0;
        d1_int      = '0;
        d1_guard    = 1'b0;
        d1_sticky   = 1'b0;
        d1_huge     = 1'b0;
        if (e_unb > int'(W)) begin
            d1_huge = 1'b1;
        end else if (e_unb < -1) begin
            d1_sticky = |significand;
        end else begin
            aligned   = VW'(significand) << SW'(e_unb + 2);
            d1_int    = aligned[VW-1:M+2];
            d1_guard  = aligned[M+1];
            d1_sticky = |aligned[M:0];
        end
    end

    logic         s1_valid;
    logic         s1_sign;
    logic         s1_signed;
    logic [2:0]   s1_rm;
    float_class_e s1_cls;
    logic         s1_huge;
    logic [W:0]   s1_int;
    logic         s1_guard;
    logic         s1_sticky;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_sign   <= 1'b0;
            s1_signed <= 1'b0;
            s1_rm     <= 3'b000;
            s1_cls    <= ClsZero;
            s1_huge   <= 1'b0;
            s1_int    <= '0;
            s1_guard  <= 1'b0;
            s1_sticky <= 1'b0;
        end else if (advance) begin
            s1_valid <= input_valid;
            if (input_valid) begin
                s1_sign   <= in_sign;
                s1_signed <= sign_mode;
                s1_rm     <= rounding_mode;
                s1_cls    <= in_cls;
                s1_huge   <= d1_huge;
                s1_int    <= d1_int;
                s1_guard  <= d1_guard;
                s1_sticky <= d1_sticky;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: round and saturate
    // ------------------------------------------------------------------
    logic         round_up;
    logic         inexact;
    logic [W+1:0] mag;
    logic [W-1:0] d2_result;
    logic         d2_nv;
    logic         d2_nx;

    always_comb begin
        round_up = 1'b0;
        case (s1_rm)
            3'b001:  round_up = 1'b0;
            3'b010:  round_up = s1_sign && (s1_guard || s1_sticky);
            3'b011:  round_up = !s1_sign && (s1_guard || s1_sticky);
            3'b100:  round_up = s1_guard;
            default: round_up = s1_guard && (s1_sticky || s1_int[0]);
        endcase
    end

    assign mag     = {1'b0, s1_int} + {{(W + 1){1'b0}}, round_up};
    assign inexact = s1_guard || s1_sticky;

    always_comb begin
        d2_result = '0;
        d2_nv     = 1'b0;
        d2_nx     = 1'b0;
        if (s1_cls == ClsNan) begin
            d2_nv     = 1'b1;
            d2_result = s1_signed ? SMAX : UMAX;
        end else if (s1_cls == ClsInf || s1_huge) begin
            d2_nv = 1'b1;
            if (!s1_sign) begin
                d2_result = s1_signed ? SMAX : UMAX;
            end else begin
                d2_result = s1_signed ? SMIN : '0;
            end
        end else if (s1_signed) begin
            if (!s1_sign && mag > SMAX_MAG) begin
                d2_nv     = 1'b1;
                d2_result = SMAX;
            end else if (s1_sign && mag > SMIN_MAG) begin
                d2_nv     = 1'b1;
                d2_result = SMIN;
            end else begin
                d2_result = s1_sign ? (~mag[W-1:0] + W'(1)) : mag[W-1:0];
                d2_nx     = inexact;
            end
        end else if (!s1_sign) begin
            if (mag > UMAX_MAG) begin
                d2_nv     = 1'b1;
                d2_result = UMAX;
            end else begin
                d2_result = mag[W-1:0];
                d2_nx     = inexact;
            end
        end else if (mag == '0) begin
            // Negative value that rounds to zero is merely inexact for unsigned.
            d2_nx = inexact;
        end else begin
            d2_nv = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            output_valid      <= 1'b0;
            converted_integer <= '0;
            flag_invalid      <= 1'b0;
            flag_inexact      <= 1'b0;
        end else if (advance) begin
            output_valid <= s1_valid;
            if (s1_valid) begin
                converted_integer <= d2_result;
                flag_invalid      <= d2_nv;
                flag_inexact      <= d2_nx;
            end
        end
    end

endmodule

// File: tb/tb_pipelined_float_to_integer_converter.sv
// Scoreboard bench for the float-to-integer converter: 32- and 64-bit instances fed in lockstep,
// expected results from a real-arithmetic reference model or hand-written constants.
module tb_pipelined_float_to_integer_converter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        input_valid = 1'b0;
    logic [31:0] input_float = '0;
    logic        sign_mode = 1'b0;
    logic [2:0]  rounding_mode = 3'b000;
    logic        output_ready = 1'b1;

    logic        ir32, ov32, nv32, nx32;
    logic [31:0] res32;
    logic        ir64, ov64, nv64, nx64;
    logic [63:0] res64;

    always #5 clock = ~clock;

    pipelined_float_to_integer_converter #(
        .INTEGER_WIDTH (32),
        .EXPONENT_WIDTH(8),
        .MANTISSA_WIDTH(23)
    ) dut32 (
        .clock            (clock),
        .reset            (reset),
        .input_valid      (input_valid),
        .input_ready      (ir32),
        .input_float      (input_float),
        .sign_mode        (sign_mode),
        .rounding_mode    (rounding_mode),
        .output_valid     (ov32),
        .output_ready     (output_ready),
        .converted_integer(res32),
        .flag_invalid     (nv32),
        .flag_inexact     (nx32)
    );

    pipelined_float_to_integer_converter #(
        .INTEGER_WIDTH (64),
        .EXPONENT_WIDTH(8),
        .MANTISSA_WIDTH(23)
    ) dut64 (
        .clock            (clock),
        .reset            (reset),
        .input_valid      (input_valid),
        .input_ready      (ir64),
        .input_float      (input_float),
        .sign_mode        (sign_mode),
        .rounding_mode    (rounding_mode),
        .output_valid     (ov64),
        .output_ready     (output_ready),
        .converted_integer(res64),
        .flag_invalid     (nv64),
        .flag_inexact     (nx64)
    );

    typedef struct {
        logic [63:0] res;
        logic        nv;
        logic        nx;
        logic [31:0] f;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];
    int   n_tests = 0;
    int   n_fail = 0;
    real  p2[0:64];
    logic dir_en = 1'b0;
    exp_t dir_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Magnitude of a binary32 operand as an exact real.
    function automatic real mag_of(input logic [31:0] f);
        real v;
        int  k;
        int  m;
        m = int'({9'd0, f[22:0]});
        v = $itor(m);
        if (f[30:23] != 8'd0) v = v + 8388608.0;
        k = (f[30:23] == 8'd0) ? -149 : int'({24'd0, f[30:23]}) - 150;
        while (k > 0) begin v = v * 2.0; k--; end
        while (k < 0) begin v = v * 0.5; k++; end
        return v;
    endfunction

    function automatic exp_t model(input logic [31:0] f, input logic sgn, input logic [2:0] rm,
                                   input int w);
        exp_t        r;
        real         a, fl, fr, m, v, hi, lo;
        logic        neg;
        logic [63:0] mask, mag, smax, smin;
        mask  = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        smax  = (64'd1 << (w - 1)) - 64'd1;
        smin  = 64'd1 << (w - 1);
        r.f   = f;
        r.nv  = 1'b0;
        r.nx  = 1'b0;
        r.res = '0;
        neg   = f[31];
        if (f[30:23] == 8'hFF) begin
            r.nv = 1'b1;
            if (f[22:0] != 23'd0 || !neg) r.res = sgn ? smax : mask;
            else r.res = sgn ? smin : 64'd0;
            return r;
        end
        a  = mag_of(f);
        fl = $floor(a);
        fr = a - fl;
        m  = fl;
        case (rm)
            3'd1: m = fl;
            3'd2: if (neg && fr > 0.0) m = fl + 1.0;
            3'd3: if (!neg && fr > 0.0) m = fl + 1.0;
            3'd4: if (fr >= 0.5) m = fl + 1.0;
            default: if (fr > 0.5 || (fr == 0.5 && $floor(fl / 2.0) * 2.0 != fl)) m = fl + 1.0;
        endcase
        v  = neg ? -m : m;
        hi = sgn ? p2[w-1] : p2[w];
        lo = sgn ? -p2[w-1] : 0.0;
        if (v >= hi) begin
            r.nv  = 1'b1;
            r.res = sgn ? smax : mask;
        end else if (v < lo) begin
            r.nv  = 1'b1;
            r.res = sgn ? smin : 64'd0;
        end else begin
            mag = '0;
            for (int b = 63; b >= 0; b--) begin
                if (m >= p2[b]) begin
                    mag[b] = 1'b1;
                    m = m - p2[b];
                end
            end
            r.res = (neg ? (~mag + 64'd1) : mag) & mask;
            r.nx  = (fr > 0.0);
        end
        return r;
    endfunction

    task automatic step(input logic v, input logic [31:0] f, input logic sm, input logic [2:0] rm,
                        input logic ordy, output logic acc);
        exp_t e;
        @(negedge clock);
        input_valid   = v;
        input_float   = f;
        sign_mode     = sm;
        rounding_mode = rm;
        output_ready  = ordy;
        #1;
        acc = v && ir32 && ir64;
        if (acc) begin
            e = model(f, sm, rm, 32);
            if (dir_en) e = dir_e;
            q32.push_back(e);
            q64.push_back(model(f, sm, rm, 64));
        end
    endtask

    task automatic send(input logic [31:0] f, input logic sm, input logic [2:0] rm, input logic rnd);
        logic acc;
        int   tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 50) begin
            step(1'b1, f, sm, rm, rnd ? logic'($urandom_range(0, 3) != 0) : 1'b1, acc);
            tries++;
        end
        if (!acc) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: input_ready stayed 0, required 1 within 50 cycles");
        end
    endtask

    task automatic send_dir(input logic [31:0] f, input logic sm, input logic [2:0] rm,
                            input logic [31:0] res, input logic nv, input logic nx);
        dir_e.res = {32'd0, res};
        dir_e.nv  = nv;
        dir_e.nx  = nx;
        dir_e.f   = f;
        dir_en    = 1'b1;
        send(f, sm, rm, 1'b0);
        dir_en    = 1'b0;
    endtask

    task automatic drain();
        logic a;
        int   i;
        i = 0;
        while ((q32.size() > 0 || q64.size() > 0) && i < 40) begin
            step(1'b0, 32'd0, 1'b0, 3'd0, 1'b1, a);
            i++;
        end
        check("drain_pending", 64'(q32.size() + q64.size()), 64'd0);
    endtask

    function automatic logic [31:0] rand_float();
        logic [31:0] f;
        int          sel;
        f   = $urandom;
        sel = $urandom_range(0, 9);
        if (sel < 6) begin
            f[30:23] = 8'($urandom_range(118, 192));
        end else if (sel < 8) begin
            f[30:23] = 8'($urandom_range(125, 152));
            f[15:0]  = 16'd0;
        end else if (sel == 8) begin
            f[30:23] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
        end
        return f;
    endfunction

    // Monitor: pop and compare whenever a result transfers; also checks stall stability.
    exp_t        m32, m64;
    logic        held = 1'b0;
    logic [31:0] held_res;
    logic        held_nv, held_nx;

    always @(negedge clock) begin
        #2;
        if (reset) begin
            held = 1'b0;
        end else begin
            if (held && ov32) begin
                check("stall_stable_res", {32'd0, res32}, {32'd0, held_res});
                check("stall_stable_flags", {62'd0, nv32, nx32}, {62'd0, held_nv, held_nx});
            end
            held     = ov32 && !output_ready;
            held_res = res32;
            held_nv  = nv32;
            held_nx  = nx32;
            if (ov32 && output_ready) begin
                if (q32.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL spurious_out32: got output %h, required no output", res32);
                end else begin
                    m32 = q32.pop_front();
                    check($sformatf("res32[%h]", m32.f), {32'd0, res32}, m32.res);
                    check($sformatf("nv32[%h]", m32.f), {63'd0, nv32}, {63'd0, m32.nv});
                    check($sformatf("nx32[%h]", m32.f), {63'd0, nx32}, {63'd0, m32.nx});
                end
            end
            if (ov64 && output_ready) begin
                if (q64.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL spurious_out64: got output %h, required no output", res64);
                end else begin
                    m64 = q64.pop_front();
                    check($sformatf("res64[%h]", m64.f), res64, m64.res);
                    check($sformatf("nv64[%h]", m64.f), {63'd0, nv64}, {63'd0, m64.nv});
                    check($sformatf("nx64[%h]", m64.f), {63'd0, nx64}, {63'd0, m64.nx});
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic        acc;
    logic        saw_drop;
    logic [31:0] burst[4];
    int          idx, cyc;

    initial begin
        p2[0] = 1.0;
        for (int i = 1; i <= 64; i++) p2[i] = p2[i-1] * 2.0;

        // Reset state
        #12;
        check("reset_ov32", {63'd0, ov32}, 64'd0);
        check("reset_ov64", {63'd0, ov64}, 64'd0);
        check("reset_res32", {32'd0, res32}, 64'd0);
        check("reset_flags32", {62'd0, nv32, nx32}, 64'd0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("ready_after_reset", {63'd0, ir32}, 64'd1);

        // Latency: pi accepted in cycle c, output_valid in cycle c+2
        send_dir(32'h40490FDB, 1'b1, 3'd0, 32'h00000003, 1'b0, 1'b1);
        step(1'b0, 32'd0, 1'b0, 3'd0, 1'b1, acc);
        check("latency_c1_ov", {63'd0, ov32}, 64'd0);
        step(1'b0, 32'd0, 1'b0, 3'd0, 1'b1, acc);
        check("latency_c2_ov", {63'd0, ov32}, 64'd1);
        drain();

        // Directed cases
        send_dir(32'h40200000, 1'b1, 3'd0, 32'd2, 1'b0, 1'b1);
        send_dir(32'h40200000, 1'b1, 3'd1, 32'd2, 1'b0, 1'b1);
        send_dir(32'h40200000, 1'b1, 3'd2, 32'd2, 1'b0, 1'b1);
        send_dir(32'h40200000, 1'b1, 3'd3, 32'd3, 1'b0, 1'b1);
        send_dir(32'h40200000, 1'b1, 3'd4, 32'd3, 1'b0, 1'b1);
        send_dir(32'h40200000, 1'b1, 3'd5, 32'd2, 1'b0, 1'b1);
        send_dir(32'hBFC00000, 1'b1, 3'd2, 32'hFFFFFFFE, 1'b0, 1'b1);
        send_dir(32'hBF000000, 1'b0, 3'd1, 32'd0, 1'b0, 1'b1);
        send_dir(32'h7FC00000, 1'b1, 3'd0, 32'h7FFFFFFF, 1'b1, 1'b0);
        send_dir(32'h4F000000, 1'b1, 3'd0, 32'h7FFFFFFF, 1'b1, 1'b0);
        send_dir(32'h4F000000, 1'b0, 3'd0, 32'h80000000, 1'b0, 1'b0);
        send_dir(32'hCF000000, 1'b1, 3'd0, 32'h80000000, 1'b0, 1'b0);
        send_dir(32'h80000000, 1'b1, 3'd0, 32'd0, 1'b0, 1'b0);
        send_dir(32'h80000000, 1'b0, 3'd3, 32'd0, 1'b0, 1'b0);
        send_dir(32'h3F000000, 1'b1, 3'd0, 32'd0, 1'b0, 1'b1);
        send_dir(32'h3FC00000, 1'b1, 3'd0, 32'd2, 1'b0, 1'b1);
        send_dir(32'hFF800000, 1'b0, 3'd0, 32'd0, 1'b1, 1'b0);
        send_dir(32'hFF800000, 1'b1, 3'd0, 32'h80000000, 1'b1, 1'b0);
        send_dir(32'h00000001, 1'b1, 3'd3, 32'd1, 1'b0, 1'b1);
        send_dir(32'h4F800000, 1'b0, 3'd0, 32'hFFFFFFFF, 1'b1, 1'b0);
        send_dir(32'hBF800000, 1'b0, 3'd0, 32'd0, 1'b1, 1'b0);
        drain();

        // Back-to-back burst with output_ready low for the first 3 cycles
        burst[0] = 32'h40490FDB;
        burst[1] = 32'hC1234567;
        burst[2] = 32'h42F6E979;
        burst[3] = 32'h3F400000;
        idx = 0;
        cyc = 0;
        saw_drop = 1'b0;
        while (idx < 4 && cyc < 40) begin
            step(1'b1, burst[idx], 1'b1, 3'd0, (cyc < 3) ? 1'b0 : 1'b1, acc);
            if (!ir32) saw_drop = 1'b1;
            if (acc) idx++;
            cyc++;
        end
        check("burst_ready_drop", {63'd0, saw_drop}, 64'd1);
        check("burst_all_accepted", 64'(idx), 64'd4);
        drain();

        // Randomized traffic with random backpressure
        for (int i = 0; i < 300; i++) begin
            send(rand_float(), logic'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'b1);
            if ($urandom_range(0, 4) == 0) step(1'b0, 32'd0, 1'b0, 3'd0, 1'b1, acc);
        end
        drain();

        // Reset with two operands in flight
        step(1'b1, 32'h40490FDB, 1'b1, 3'd0, 1'b0, acc);
        step(1'b1, 32'h40200000, 1'b1, 3'd0, 1'b0, acc);
        @(negedge clock);
        input_valid = 1'b0;
        reset       = 1'b1;
        #1;
        check("midreset_ov32", {63'd0, ov32}, 64'd0);
        check("midreset_ov64", {63'd0, ov64}, 64'd0);
        q32.delete();
        q64.delete();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) step(1'b0, 32'd0, 1'b0, 3'd0, 1'b1, acc);
        check("post_reset_no_output", {62'd0, ov32, ov64}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
